// File: rtl/memory_write_fsm_pkg.sv
// Shared encodings for the multicycle memory controller FSMs.
// Holds the state encoding, the memory-instruction op code and the datapath
// mux/ALU select encodings. The memory-read FSM imports this package too.
package memory_write_fsm_pkg;

    typedef enum logic [1:0] {
        FETCH    = 2'b00,
        DECODE   = 2'b01,
        MEMADR   = 2'b10,
        MEMWRITE = 2'b11
    } stateT;

    localparam logic [1:0] OP_MEM        = 2'b01;

    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    localparam logic [1:0] ALUOP_ADD     = 2'b00;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/memory_write_fsm_if.sv
// Control bundle between the store FSM and the datapath / data memory.
//   Op, Func, MemReady : instruction fields and memory write acknowledge
//   AdrSrc .. MemErr   : datapath selects, enables and status pulses
// master : the controller (drives the control outputs)
// slave  : the datapath / memory side (drives Op, Func, MemReady)
interface memory_write_fsm_if;

    logic [1:0] Op;
    logic       Func;
    logic       MemReady;

    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ResultSrc;
    logic       IRWrite;
    logic       NextPC;
    logic       RegWrite;
    logic       MemWrite;
    logic       StoreDone;
    logic       MemErr;

    modport master (
        input  Op, Func, MemReady,
        output AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
               IRWrite, NextPC, RegWrite, MemWrite, StoreDone, MemErr
    );

    modport slave (
        output Op, Func, MemReady,
        input  AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
               IRWrite, NextPC, RegWrite, MemWrite, StoreDone, MemErr
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts MEMWRITE cycles spent waiting for MemReady.
//   clk, reset : clock and synchronous active-high reset
//   clear      : zero the count (asserted the cycle before MEMWRITE)
//   enable     : count one more waiting cycle
//   expired    : count has reached TIMEOUT-1 (this is the last allowed wait)
module mem_wait_timer #(
    parameter int TIMEOUT = 8       // legal 2..16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_write_fsm.sv
// Multicycle controller slice that handles STR instructions.
//   clk, reset : clock and synchronous active-high reset
//   bus        : control bundle (master side), see memory_write_fsm_if
// Outputs are a Moore decode of the state except StoreDone/MemErr, which also
// look at MemReady and the wait timer. All outputs are forced low in reset.
module memory_write_fsm
    import memory_write_fsm_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    memory_write_fsm_if.master bus
);

    stateT state;
    stateT stateNext;
    logic  timerClear;
    logic  timerEnable;
    logic  timerExpired;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) uWaitTimer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timerClear),
        .enable  (timerEnable),
        .expired (timerExpired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        timerClear    = 1'b0;
        timerEnable   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = SRCB_REG;
        bus.ALUOp     = ALUOP_ADD;
        bus.ResultSrc = RES_ALUOUT;
        bus.IRWrite   = 1'b0;
        bus.NextPC    = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.StoreDone = 1'b0;
        bus.MemErr    = 1'b0;

        if (!reset) begin
            case (state)
                FETCH: begin
                    bus.ALUSrcA   = 1'b1;
                    bus.ALUSrcB   = SRCB_FOUR;
                    bus.ResultSrc = RES_ALURESULT;
                    bus.IRWrite   = 1'b1;
                    bus.NextPC    = 1'b1;
                    stateNext     = DECODE;
                end
                DECODE: begin
                    bus.ALUSrcA   = 1'b1;
                    bus.ALUSrcB   = SRCB_FOUR;
                    bus.ResultSrc = RES_ALURESULT;
                    if (bus.Op == OP_MEM && !bus.Func) begin
                        stateNext = MEMADR;
                    end else begin
                        stateNext = FETCH;
                    end
                end
                MEMADR: begin
                    bus.ALUSrcB = SRCB_IMM;
                    // Clearing here means the count is zero on the first MEMWRITE cycle.
                    timerClear  = 1'b1;
                    stateNext   = MEMWRITE;
                end
                MEMWRITE: begin
                    bus.AdrSrc   = 1'b1;
                    bus.MemWrite = 1'b1;
                    // MemReady is checked first so an ack on the last allowed
                    // cycle still counts as a successful store.
                    if (bus.MemReady) begin
                        bus.StoreDone = 1'b1;
                        stateNext     = FETCH;
                    end else begin
                        timerEnable = 1'b1;
                        if (timerExpired) begin
                            bus.MemErr = 1'b1;
                            stateNext  = FETCH;
                        end
                    end
                end
                default: stateNext = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_write_fsm.sv
// Directed bench for memory_write_fsm with TIMEOUT=8.
// Outputs are packed {AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc, IRWrite,
// NextPC, RegWrite, MemWrite, StoreDone, MemErr} and compared against
// hand-written per-state vectors.
module tb_memory_write_fsm;
    import memory_write_fsm_pkg::*;

    localparam logic [13:0] O_ZERO   = 14'b0_0_00_00_00_0_0_0_0_0_0;
    localparam logic [13:0] O_FETCH  = 14'b0_1_10_00_10_1_1_0_0_0_0;
    localparam logic [13:0] O_DECODE = 14'b0_1_10_00_10_0_0_0_0_0_0;
    localparam logic [13:0] O_MEMADR = 14'b0_0_01_00_00_0_0_0_0_0_0;
    localparam logic [13:0] O_MW     = 14'b1_0_00_00_00_0_0_0_1_0_0;
    localparam logic [13:0] O_SD     = 14'b0_0_00_00_00_0_0_0_0_1_0;
    localparam logic [13:0] O_ME     = 14'b0_0_00_00_00_0_0_0_0_0_1;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [13:0] obs;

    always #5 clk = ~clk;

    memory_write_fsm_if bus();

    memory_write_fsm #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign obs = {bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ResultSrc,
                  bus.IRWrite, bus.NextPC, bus.RegWrite, bus.MemWrite,
                  bus.StoreDone, bus.MemErr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.Op       = 2'b00;
        bus.Func     = 1'b0;
        bus.MemReady = 1'b0;
        tick();
        tick();
        #1;
        checks++;
        if (obs !== O_ZERO) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs, O_ZERO);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== O_FETCH) begin
            errors++;
            $display("FAIL reset_release_fetch: got %b expected %b", obs, O_FETCH);
        end
    endtask

    task automatic test_str_fast();
        logic [13:0] seq [5];
        int mw = 0;
        seq = '{O_FETCH, O_DECODE, O_MEMADR, O_MW | O_SD, O_FETCH};
        bus.Op       = 2'b01;
        bus.Func     = 1'b0;
        bus.MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL str_fast_cycle%0d: got %b expected %b", i + 1, obs, seq[i]);
            end
            if (bus.MemWrite === 1'b1) mw++;
            if (i < 4) tick();
        end
        checks++;
        if (mw !== 1) begin
            errors++;
            $display("FAIL str_fast_memwrite_cycles: got %0d expected 1", mw);
        end
        bus.MemReady = 1'b0;
    endtask

    task automatic test_non_store(input logic [1:0] op, input logic func, input string name);
        logic [13:0] seq [3];
        int mw = 0;
        seq = '{O_FETCH, O_DECODE, O_FETCH};
        bus.Op       = op;
        bus.Func     = func;
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== seq[i]) begin
                errors++;
                $display("FAIL %s_cycle%0d: got %b expected %b", name, i + 1, obs, seq[i]);
            end
            if (bus.MemWrite === 1'b1) mw++;
            if (i < 2) tick();
        end
        checks++;
        if (mw !== 0) begin
            errors++;
            $display("FAIL %s_memwrite_cycles: got %0d expected 0", name, mw);
        end
    endtask

    // readyAt = MEMWRITE cycle (1-based) in which MemReady is raised; 0 = never.
    task automatic test_store_wait(input int readyAt, input int expLen, input logic expErr,
                                   input string name);
        logic [13:0] exp;
        int mw = 0;
        bus.Op       = 2'b01;
        bus.Func     = 1'b0;
        bus.MemReady = 1'b0;
        #1;
        checks++;
        if (obs !== O_FETCH) begin
            errors++;
            $display("FAIL %s_fetch: got %b expected %b", name, obs, O_FETCH);
        end
        tick();
        #1;
        checks++;
        if (obs !== O_DECODE) begin
            errors++;
            $display("FAIL %s_decode: got %b expected %b", name, obs, O_DECODE);
        end
        tick();
        #1;
        checks++;
        if (obs !== O_MEMADR) begin
            errors++;
            $display("FAIL %s_memadr: got %b expected %b", name, obs, O_MEMADR);
        end
        tick();
        for (int i = 1; i <= expLen; i++) begin
            bus.MemReady = (i == readyAt);
            #1;
            exp = O_MW;
            if (i == expLen) exp = exp | (expErr ? O_ME : O_SD);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL %s_memwrite%0d: got %b expected %b", name, i, obs, exp);
            end
            if (bus.MemWrite === 1'b1) mw++;
            tick();
        end
        bus.MemReady = 1'b0;
        #1;
        checks++;
        if (obs !== O_FETCH) begin
            errors++;
            $display("FAIL %s_return_fetch: got %b expected %b", name, obs, O_FETCH);
        end
        checks++;
        if (mw !== expLen) begin
            errors++;
            $display("FAIL %s_memwrite_cycles: got %0d expected %0d", name, mw, expLen);
        end
    endtask

    task automatic test_reset_mid_write();
        bus.Op       = 2'b01;
        bus.Func     = 1'b0;
        bus.MemReady = 1'b0;
        tick();
        tick();
        tick();
        #1;
        checks++;
        if (obs !== O_MW) begin
            errors++;
            $display("FAIL rst_mid_memwrite1: got %b expected %b", obs, O_MW);
        end
        tick();
        #1;
        checks++;
        if (obs !== O_MW) begin
            errors++;
            $display("FAIL rst_mid_memwrite2: got %b expected %b", obs, O_MW);
        end
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if (obs !== O_ZERO) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b expected %b", obs, O_ZERO);
        end
        checks++;
        if (dut.state !== FETCH) begin
            errors++;
            $display("FAIL rst_mid_state: got %0d expected %0d", dut.state, FETCH);
        end
        checks++;
        if (dut.uWaitTimer.count !== 3'd0) begin
            errors++;
            $display("FAIL rst_mid_wait_count: got %0d expected 0", dut.uWaitTimer.count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== O_FETCH) begin
            errors++;
            $display("FAIL rst_mid_release_fetch: got %b expected %b", obs, O_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_str_fast();
        test_non_store(2'b01, 1'b1, "ldr");
        test_non_store(2'b00, 1'b0, "op00");
        test_non_store(2'b10, 1'b0, "op10");
        test_store_wait(3, 3, 1'b0, "ready3");
        test_store_wait(0, 8, 1'b1, "timeout");
        test_store_wait(8, 8, 1'b0, "ready8");
        test_reset_mid_write();
        test_store_wait(0, 8, 1'b1, "timeout_after_rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_write_fsm.md
MEMORY_WRITE_FSM -- requirements
Module: memory_write_fsm

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, the maximum number of MEMWRITE cycles waiting for MemReady; legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates happen on the rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port Op, input, 2, instruction op field; 2'b01 means memory instruction.
REQ-005 The block SHALL have port Func, input, 1, load/store bit; 0 means STR, 1 means LDR.
REQ-006 The block SHALL have port MemReady, input, 1, data memory write acknowledge.
REQ-007 The block SHALL have the following outputs, one per entry:
- AdrSrc, 1: memory address select; 0 = PC, 1 = ALU result.
- ALUSrcA, 1: ALU A select; 0 = register, 1 = PC.
- ALUSrcB, 2: ALU B select; 00 = register, 01 = immediate, 10 = constant 4.
- ALUOp, 2: ALU operation; 00 = add.
- ResultSrc, 2: result select; 00 = ALUOut, 10 = ALU result.
- IRWrite, 1: instruction register write enable.
- NextPC, 1: PC update enable.
- RegWrite, 1: register file write enable; always 0 in this block.
- MemWrite, 1: data memory write strobe.
- StoreDone, 1: one-cycle pulse on store completion.
- MemErr, 1: one-cycle pulse on write timeout.

Function
REQ-008 The block SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMWRITE; StoreDone and MemErr additionally depend on MemReady and the wait count.
REQ-009 In FETCH, outputs SHALL be AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=1, NextPC=1, and all other outputs 0; the next state SHALL be DECODE unconditionally.
REQ-010 In DECODE, outputs SHALL be ALUSrcA=1, ALUSrcB=10, ALUOp=00, ResultSrc=10, and all other outputs 0.
REQ-011 DECODE SHALL go to MEMADR if Op=01 and Func=0; otherwise it SHALL go to FETCH. Op and Func are sampled only in DECODE.
REQ-012 In MEMADR, outputs SHALL be ALUSrcA=0, ALUSrcB=01, ALUOp=00, and all other outputs 0; the next state SHALL be MEMWRITE.
REQ-013 In MEMWRITE, outputs SHALL be AdrSrc=1, MemWrite=1, ResultSrc=00, and all other enables 0; MemWrite SHALL stay high for every MEMWRITE cycle.
REQ-014 MEMWRITE with MemReady=1 SHALL assert StoreDone that same cycle and go to FETCH.
REQ-015 A wait counter SHALL clear on entry to MEMWRITE and increment on each MEMWRITE cycle with MemReady=0.
REQ-016 If the wait counter equals TIMEOUT-1 and MemReady=0, the block SHALL assert MemErr that cycle and go to FETCH.
REQ-017 If MemReady=1 and the timeout condition occur in the same cycle, MemReady SHALL win: StoreDone=1, MemErr=0.
REQ-018 Minimum STR latency SHALL be 4 cycles (FETCH, DECODE, MEMADR, MEMWRITE); a non-store instruction SHALL take 2 cycles.
REQ-019 StoreDone and MemErr SHALL never be high together, and neither SHALL be high outside MEMWRITE.

Reset
REQ-020 reset=1 at a clock edge SHALL force the state to FETCH and the wait counter to 0, from any state including mid-MEMWRITE.
REQ-021 While reset=1, all outputs SHALL be driven 0; the first cycle after reset deasserts SHALL show FETCH outputs.

Structure
REQ-022 A shared package SHALL hold the state encoding, the OP_MEM=2'b01 constant, and the ALUSrcB, ALUOp and ResultSrc encodings, all shared with the memory-read FSM.
REQ-023 The wait counter SHALL be a sub-module mem_wait_timer with clear, enable and expired ports; the FSM and output decode stay in memory_write_fsm.

Verification
REQ-024 The bench SHALL cover:
- Reset 2 cycles, then Op=01, Func=0, MemReady=1: states FETCH, DECODE, MEMADR, MEMWRITE, FETCH; MemWrite=1 for exactly 1 cycle; StoreDone pulses in cycle 4.
- Op=01, Func=1 (LDR): FETCH, DECODE, FETCH; MemWrite never asserted.
- STR with MemReady rising in the 3rd MEMWRITE cycle: MemWrite high for 3 cycles; StoreDone=1 in the 3rd; MemErr=0.
- STR with MemReady held at 0 and TIMEOUT=8: MemWrite high for 8 cycles; MemErr pulses in the 8th; return to FETCH.
- STR with MemReady=1 in the 8th MEMWRITE cycle: StoreDone=1, MemErr=0.
- reset asserted in the 2nd MEMWRITE cycle: next cycle all outputs 0; after release, FETCH with wait count 0.
